// File: rtl/brv32p_pkg.sv
// Shared core types: operation encoding for the RV32M multiply/divide unit.
// M-ops mirror funct3; MD_NONE marks an EX-stage op that is not an M-op.
package brv32p_pkg;

  typedef enum logic [3:0] {
    MD_MUL    = 4'h0,
    MD_MULH   = 4'h1,
    MD_MULHSU = 4'h2,
    MD_MULHU  = 4'h3,
    MD_DIV    = 4'h4,
    MD_DIVU   = 4'h5,
    MD_REM    = 4'h6,
    MD_REMU   = 4'h7,
    MD_NONE   = 4'h8
  } md_op_e;

endpackage

// File: rtl/md_issue_seq_if.sv
// Bundle between EX/WB, the issue sequencer and the multiply/divide unit.
// slave is the sequencer's view; master is the surrounding pipeline and unit.
interface md_issue_seq_if;
  import brv32p_pkg::*;

  logic        req_valid;
  logic        req_ready;
  md_op_e      req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        md_start;
  md_op_e      md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_busy;
  logic        md_valid;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
    input  md_result, md_busy, md_valid,
    output req_ready, stall, wb_valid, wb_rd, wb_data,
    output md_start, md_op, md_a, md_b
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
    output md_result, md_busy, md_valid,
    input  req_ready, stall, wb_valid, wb_rd, wb_data,
    input  md_start, md_op, md_a, md_b
  );

endinterface

// File: rtl/md_issue_seq.sv
// Issue sequencer for the RV32M mul/div unit: starts ops, stalls on divides,
// drains flushed divides. Define MD_DIV_CACHE_EN for a one-entry divide result cache.
module md_issue_seq
  import brv32p_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  md_issue_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  md_op_e      r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_accept;
  logic        w_hit;
  logic [31:0] w_hit_res;
  logic        w_ld_div;
  logic        w_start;
  logic        w_wb_en;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_data;

  assign w_is_mul = bus.req_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  assign w_is_div = bus.req_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  assign w_accept = bus.req_valid & (r_state == IDLE) & ~bus.flush;

`ifdef MD_DIV_CACHE_EN
  logic        r_c_vld;
  md_op_e      r_c_op;
  logic [31:0] r_c_a;
  logic [31:0] r_c_b;
  logic [31:0] r_c_res;

  assign w_hit     = r_c_vld & w_is_div & (bus.req_op == r_c_op)
                   & (bus.req_a == r_c_a) & (bus.req_b == r_c_b);
  assign w_hit_res = r_c_res;
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = 32'h0;
`endif

  assign w_ld_div = w_accept & w_is_div & ~w_hit;
  assign w_start  = w_accept & (w_is_mul | w_ld_div);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wb_en     = 1'b0;
    w_wb_rd     = bus.req_rd;
    w_wb_data   = bus.md_result;
    case (r_state)
      IDLE: begin
        if (w_ld_div) begin
          w_state_nxt = DIV_WAIT;
        end else if (w_accept & w_hit) begin
          w_wb_en   = 1'b1;
          w_wb_data = w_hit_res;
        end else if (w_accept & w_is_mul & bus.md_valid) begin
          w_wb_en = 1'b1;
        end
      end
      DIV_WAIT: begin
        w_wb_rd = r_rd;
        if (bus.md_valid) begin
          w_state_nxt = IDLE;
          w_wb_en     = ~bus.flush;
        end else if (bus.flush) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.md_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= MD_MUL;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_rd       <= 5'h0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'h0;
      r_wb_data  <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= w_wb_en;
      if (w_wb_en) begin
        r_wb_rd   <= w_wb_rd;
        r_wb_data <= w_wb_data;
      end
      if (w_ld_div) begin
        r_op <= bus.req_op;
        r_a  <= bus.req_a;
        r_b  <= bus.req_b;
        r_rd <= bus.req_rd;
      end
    end
  end

`ifdef MD_DIV_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_vld <= 1'b0;
    end else if ((r_state == DIV_WAIT) & bus.md_valid & ~bus.flush) begin
      r_c_vld <= 1'b1;
    end
  end

  // NOTE: the cache payload is not reset; it is qualified by r_c_vld, which is.
  always_ff @(posedge clk) begin
    if ((r_state == DIV_WAIT) & bus.md_valid & ~bus.flush) begin
      r_c_op  <= r_op;
      r_c_a   <= r_a;
      r_c_b   <= r_b;
      r_c_res <= bus.md_result;
    end
  end
`endif

  assign bus.req_ready = (r_state == IDLE);
  assign bus.stall     = (r_state == DIV_WAIT)
                       | ((r_state == IDLE) & bus.req_valid & w_is_div & ~bus.flush & ~w_hit);
  assign bus.md_start  = w_start;
  assign bus.md_op     = w_start ? bus.req_op : r_op;
  assign bus.md_a      = w_start ? bus.req_a  : r_a;
  assign bus.md_b      = w_start ? bus.req_b  : r_b;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;

  // Starting while the unit is still iterating would corrupt its dividend capture.
  a_start_idle: assert property (@(posedge clk) disable iff (rst) bus.md_start |-> !bus.md_busy);

endmodule

// File: tb/tb_md_issue_seq.sv
// Bench for md_issue_seq: behavioural mul/div unit, cycle-level scoreboard
// driven from the timing rules, and directed vectors with literal expectations.
module tb_md_issue_seq;
  import brv32p_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  md_issue_seq_if bus ();

  md_issue_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic bit is_mul_op(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

  function automatic bit is_div_op(md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  // RV32M arithmetic, including divide-by-zero and overflow results.
  function automatic logic [31:0] ref_md(md_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] sa32, sb32, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa32 = a;
    sb32 = b;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa32 / sb32;
        return q;
      end
      MD_DIVU:   return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      MD_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa32 % sb32;
        return q;
      end
      MD_REMU:   return (b == 32'h0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  task automatic tally(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tally(name, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    tally(name, {31'h0, act}, {31'h0, exp});
  endtask

  // ---------------- behavioural multiply/divide unit ----------------
  md_op_e      u_op;
  logic [31:0] u_a, u_b;
  logic        u_busy;
  int          u_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_left <= 0;
    end else if (u_busy) begin
      if (u_left == 0) u_busy <= 1'b0;
      else u_left <= u_left - 1;
    end else if (bus.md_start && is_div_op(bus.md_op)) begin
      u_busy <= 1'b1;
      u_left <= 33;
      u_op   <= bus.md_op;
      u_a    <= bus.md_a;
      u_b    <= bus.md_b;
    end
  end

  assign bus.md_busy   = u_busy;
  assign bus.md_valid  = (bus.md_start && is_mul_op(bus.md_op)) || (u_busy && u_left == 0);
  assign bus.md_result = u_busy ? ref_md(u_op, u_a, u_b) : ref_md(bus.md_op, bus.md_a, bus.md_b);

  // ---------------- scoreboard: absolute-cycle timing rules ----------------
  int          m_div_n = 0;
  bit          m_div_act = 1'b0;
  bit          m_div_fl = 1'b0;
  md_op_e      m_dop = MD_MUL;
  logic [31:0] m_da = '0, m_db = '0;
  logic [4:0]  m_drd = '0;
  int          m_wb_cyc = -1;
  logic [4:0]  m_wb_rd = '0;
  logic [31:0] m_wb_data = '0;
  bit          m_c_vld = 1'b0;
  md_op_e      m_c_op = MD_MUL;
  logic [31:0] m_c_a = '0, m_c_b = '0, m_c_res = '0;

  always @(negedge clk) begin : cmp
    bit win, ism, isd, hit, rdy, acc, strt, stl;
    if (rst) begin
      check_b("rst_req_ready", bus.req_ready, 1'b1);
      check_b("rst_stall",     bus.stall,     1'b0);
      check_b("rst_wb_valid",  bus.wb_valid,  1'b0);
      check("rst_wb_rd",       32'(bus.wb_rd), 32'h0);
      check("rst_wb_data",     bus.wb_data,   32'h0);
      check_b("rst_md_start",  bus.md_start,  1'b0);
      check("rst_md_op",       32'(bus.md_op), 32'(MD_MUL));
      check("rst_md_a",        bus.md_a,      32'h0);
      check("rst_md_b",        bus.md_b,      32'h0);
      m_div_act = 1'b0;
      m_div_fl  = 1'b0;
      m_wb_cyc  = -1;
      m_c_vld   = 1'b0;
    end else begin
      win = m_div_act && (cyc > m_div_n) && (cyc <= m_div_n + 34);
      ism = is_mul_op(bus.req_op);
      isd = is_div_op(bus.req_op);
      hit = 1'b0;
`ifdef MD_DIV_CACHE_EN
      hit = m_c_vld && isd && (bus.req_op == m_c_op) && (bus.req_a == m_c_a) && (bus.req_b == m_c_b);
`endif
      rdy  = !win;
      acc  = bus.req_valid && rdy && !bus.flush && (ism || isd);
      strt = acc && !hit;
      stl  = win ? !m_div_fl : (bus.req_valid && isd && !bus.flush && !hit);

      check_b("sb_req_ready", bus.req_ready, rdy);
      check_b("sb_stall",     bus.stall,     stl);
      check_b("sb_md_start",  bus.md_start,  strt);
      check_b("sb_wb_valid",  bus.wb_valid,  m_wb_cyc == cyc);
      if (m_wb_cyc == cyc) begin
        check("sb_wb_rd",   32'(bus.wb_rd), 32'(m_wb_rd));
        check("sb_wb_data", bus.wb_data,    m_wb_data);
      end
      if (strt) begin
        check("sb_md_op_issue", 32'(bus.md_op), 32'(bus.req_op));
        check("sb_md_a_issue",  bus.md_a, bus.req_a);
        check("sb_md_b_issue",  bus.md_b, bus.req_b);
      end else if (win && !m_div_fl) begin
        check("sb_md_op_hold", 32'(bus.md_op), 32'(m_dop));
        check("sb_md_a_hold",  bus.md_a, m_da);
        check("sb_md_b_hold",  bus.md_b, m_db);
      end

      if (win && bus.flush) m_div_fl = 1'b1;
      if (win && cyc == m_div_n + 34) begin
        if (!m_div_fl) begin
          m_wb_cyc  = cyc + 1;
          m_wb_rd   = m_drd;
          m_wb_data = ref_md(m_dop, m_da, m_db);
          m_c_vld   = 1'b1;
          m_c_op    = m_dop;
          m_c_a     = m_da;
          m_c_b     = m_db;
          m_c_res   = m_wb_data;
        end
        m_div_act = 1'b0;
      end
      if (acc) begin
        if (ism || hit) begin
          m_wb_cyc  = cyc + 1;
          m_wb_rd   = bus.req_rd;
          m_wb_data = hit ? m_c_res : ref_md(bus.req_op, bus.req_a, bus.req_b);
        end else begin
          m_div_act = 1'b1;
          m_div_n   = cyc;
          m_div_fl  = 1'b0;
          m_dop     = bus.req_op;
          m_da      = bus.req_a;
          m_db      = bus.req_b;
          m_drd     = bus.req_rd;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next();
  endtask

  task automatic div_op(input string nm, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int n;
    next();
    n = cyc;
    drive(op, a, b, rd);
    wait_to(n + 35);
    @(negedge clk);
    check_b({nm, "_wb_valid"}, bus.wb_valid, 1'b1);
    check({nm, "_wb_data"}, bus.wb_data, exp);
    check({nm, "_wb_rd"}, 32'(bus.wb_rd), 32'(rd));
  endtask

  md_op_e      b_op [4] = '{MD_MULH, MD_MULHSU, MD_MULHU, MD_MUL};
  logic [31:0] b_a  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
  logic [31:0] b_b  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000010};
  logic [31:0] b_x  [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h23456780};

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_op    = MD_NONE;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_rd    = '0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single MUL: 7 * -3
    next(); drive(MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd3);
    @(negedge clk);
    check_b("mul_stall", bus.stall, 1'b0);
    check_b("mul_start", bus.md_start, 1'b1);
    next(); @(negedge clk);
    check_b("mul_wb_valid", bus.wb_valid, 1'b1);
    check("mul_wb_data", bus.wb_data, 32'hFFFFFFEB);
    check("mul_wb_rd", 32'(bus.wb_rd), 32'd3);

    // back-to-back high-half multiplies, one writeback per cycle
    for (int i = 0; i < 5; i++) begin
      next();
      if (i < 4) drive(b_op[i], b_a[i], b_b[i], 5'(10 + i));
      @(negedge clk);
      if (i > 0) begin
        check_b("b2b_wb_valid", bus.wb_valid, 1'b1);
        check("b2b_wb_data", bus.wb_data, b_x[i-1]);
        check("b2b_wb_rd", 32'(bus.wb_rd), 32'(9 + i));
      end
    end

    // DIVU 100/7 with an ignored MUL presented mid-divide, REM accepted on return
    next(); n = cyc; drive(MD_DIVU, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    check_b("divu_stall_n", bus.stall, 1'b1);
    check_b("divu_start_n", bus.md_start, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      next();
      if (k == 10) drive(MD_MUL, 32'd3, 32'd3, 5'd7);
      @(negedge clk);
      check_b("divu_stall_wait", bus.stall, 1'b1);
      check_b("divu_start_wait", bus.md_start, 1'b0);
      if (k == 10) check_b("divu_ready_wait", bus.req_ready, 1'b0);
    end
    next(); drive(MD_REM, 32'hFFFFFFF9, 32'd2, 5'd6);
    @(negedge clk);
    check_b("divu_wb_valid", bus.wb_valid, 1'b1);
    check("divu_wb_rd", 32'(bus.wb_rd), 32'd5);
    check("divu_wb_data", bus.wb_data, 32'd14);
    check_b("divu_stall_end", bus.stall, 1'b1);
    check_b("rem_start_on_return", bus.md_start, 1'b1);
    n = cyc;
    wait_to(n + 35); @(negedge clk);
    check_b("rem_wb_valid", bus.wb_valid, 1'b1);
    check("rem_wb_data", bus.wb_data, 32'hFFFFFFFF);

    div_op("div_by_zero",  MD_DIV,  32'd42, 32'd0, 5'd7, 32'hFFFFFFFF);
    div_op("remu_by_zero", MD_REMU, 32'd42, 32'd0, 5'd8, 32'd42);
    div_op("div_overflow", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000);

    // flush mid-divide: drain, then MUL on the return cycle
    next(); n = cyc; drive(MD_DIVU, 32'd100, 32'd7, 5'd5);
    wait_to(n + 10); bus.flush = 1'b1;
    @(negedge clk);
    check_b("flush_stall_f", bus.stall, 1'b1);
    next(); @(negedge clk);
    check_b("flush_stall_f1", bus.stall, 1'b0);
    check_b("flush_ready_f1", bus.req_ready, 1'b0);
    wait_to(n + 34); @(negedge clk);
    check_b("flush_ready_n34", bus.req_ready, 1'b0);
    next(); drive(MD_MUL, 32'd5, 32'd6, 5'd9);
    @(negedge clk);
    check_b("flush_ready_n35", bus.req_ready, 1'b1);
    check_b("flush_no_wb", bus.wb_valid, 1'b0);
    check_b("flush_mul_start", bus.md_start, 1'b1);
    next(); @(negedge clk);
    check_b("flush_mul_wb_valid", bus.wb_valid, 1'b1);
    check("flush_mul_wb_data", bus.wb_data, 32'd30);

    // flush coinciding with md_valid discards the result
    next(); n = cyc; drive(MD_DIVU, 32'd100, 32'd7, 5'd5);
    wait_to(n + 34); bus.flush = 1'b1;
    @(negedge clk);
    check_b("flushv_stall", bus.stall, 1'b1);
    next(); @(negedge clk);
    check_b("flushv_no_wb", bus.wb_valid, 1'b0);
    check_b("flushv_ready", bus.req_ready, 1'b1);

    // flush does not kill an older mul writeback; flush blocks a same-cycle accept
    next(); drive(MD_MUL, 32'd2, 32'd3, 5'd4);
    next(); bus.flush = 1'b1;
    @(negedge clk);
    check_b("flush_keeps_wb", bus.wb_valid, 1'b1);
    check("flush_keeps_data", bus.wb_data, 32'd6);
    next(); drive(MD_MUL, 32'd2, 32'd3, 5'd4); bus.flush = 1'b1;
    @(negedge clk);
    check_b("flush_blocks_start", bus.md_start, 1'b0);
    next(); @(negedge clk);
    check_b("flush_blocks_wb", bus.wb_valid, 1'b0);

    // non-M op is ignored
    next(); drive(MD_NONE, 32'd1, 32'd1, 5'd1);
    @(negedge clk);
    check_b("nonm_start", bus.md_start, 1'b0);
    check_b("nonm_stall", bus.stall, 1'b0);
    next(); @(negedge clk);
    check_b("nonm_wb", bus.wb_valid, 1'b0);

    // reset mid-divide
    next(); n = cyc; drive(MD_DIVU, 32'd100, 32'd7, 5'd5);
    wait_to(n + 20); rst = 1'b1;
    @(negedge clk);
    check_b("rstmid_stall", bus.stall, 1'b0);
    check_b("rstmid_ready", bus.req_ready, 1'b1);
    next(); rst = 1'b0;
    wait_to(n + 35); @(negedge clk);
    check_b("rstmid_no_wb", bus.wb_valid, 1'b0);
    div_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 5'd11, 32'd3);

    // repeated divide: cache hit when enabled, full latency otherwise
    div_op("cache_first", MD_DIVU, 32'd100, 32'd7, 5'd12, 32'd14);
    next(); n = cyc; drive(MD_DIVU, 32'd100, 32'd7, 5'd13);
    @(negedge clk);
`ifdef MD_DIV_CACHE_EN
    check_b("cache_no_start", bus.md_start, 1'b0);
    check_b("cache_no_stall", bus.stall, 1'b0);
    next(); @(negedge clk);
    check_b("cache_wb_valid", bus.wb_valid, 1'b1);
    check("cache_wb_data", bus.wb_data, 32'd14);
    check("cache_wb_rd", 32'(bus.wb_rd), 32'd13);
`else
    check_b("nocache_start", bus.md_start, 1'b1);
    check_b("nocache_stall", bus.stall, 1'b1);
    next(); @(negedge clk);
    check_b("nocache_no_early_wb", bus.wb_valid, 1'b0);
    wait_to(n + 35); @(negedge clk);
    check_b("nocache_wb_valid", bus.wb_valid, 1'b1);
    check("nocache_wb_data", bus.wb_data, 32'd14);
`endif

    repeat (3) next();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
